// File: rtl/ksa_swap_loop.sv
// ksa_swap_loop: second RC4 key-scheduling pass over the 256x8 S-box RAM.
// The block walks i = 0..255. For each i it reads S[i], updates
// j = j + S[i] + key[i mod 3], reads S[j], and then writes the two entries swapped.
// The RAM has a registered address and an unregistered output, so each read
// costs one address cycle and one wait cycle.
// Every output is registered. The combinational block computes the output values
// that belong to the state being entered.
module ksa_swap_loop #(
    parameter int KEY_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_flag,
    input  logic [23:0] secret_key,
    input  logic [7:0]  q,
    output logic [7:0]  address,
    output logic [7:0]  data,
    output logic        wren,
    output logic        done_flag
);

    // Last key index before kidx wraps back to byte 0.
    localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_I = 3'd1,
        ST_WT_I = 3'd2,
        ST_RD_J = 3'd3,
        ST_WT_J = 3'd4,
        ST_WR_I = 3'd5,
        ST_WR_J = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [1:0] kidx_q, kidx_d;
    logic [7:0] address_q, address_d;
    logic [7:0] data_q, data_d;
    logic       wren_q, wren_d;
    logic       done_q, done_d;

    // Key byte 0 is the most significant byte of the 24-bit key.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        logic [7:0] kb;
        case (idx)
            2'd0:    kb = key[23:16];
            2'd1:    kb = key[15:8];
            default: kb = key[7:0];
        endcase
        return kb;
    endfunction

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            si_q      <= 8'd0;
            kidx_q    <= 2'd0;
            address_q <= 8'd0;
            data_q    <= 8'd0;
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            kidx_q    <= kidx_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            done_q    <= done_d;
        end
    end

    // Next state and next registered outputs. The data register also serves as
    // the S[j] capture, because S[j] is written to S[i] directly.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        kidx_d    = kidx_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        if ((state_q != ST_IDLE) && !start_flag) begin
            // Abort: leave the RAM partially permuted. The next start begins again at i=0.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_flag) begin
                        state_d   = ST_RD_I;
                        i_d       = 8'd0;
                        j_d       = 8'd0;
                        kidx_d    = 2'd0;
                        address_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_I: begin
                    state_d = ST_WT_I;
                end
                ST_WT_I: begin
                    si_d      = q;
                    j_d       = j_q + q + key_byte(secret_key, kidx_q);
                    address_d = j_d;
                    state_d   = ST_RD_J;
                end
                ST_RD_J: begin
                    state_d = ST_WT_J;
                end
                ST_WT_J: begin
                    address_d = i_q;
                    data_d    = q;
                    wren_d    = 1'b1;
                    state_d   = ST_WR_I;
                end
                ST_WR_I: begin
                    address_d = j_q;
                    data_d    = si_q;
                    wren_d    = 1'b1;
                    state_d   = ST_WR_J;
                end
                ST_WR_J: begin
                    if (i_q == 8'd255) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        i_d       = i_q + 8'd1;
                        kidx_d    = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
                        address_d = i_q + 8'd1;
                        state_d   = ST_RD_I;
                    end
                end
                ST_DONE: begin
                    // Hold here until start_flag drops. There is no automatic restart.
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign address   = address_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign done_flag = done_q;

endmodule
